// File: rtl/seq_match_ctrl_if.sv
// rtl/seq_match_ctrl_if.sv - command, config, serial lane and status bundle for seq_match_ctrl
interface seq_match_ctrl_if #(
    parameter int MAXLEN = 8,
    parameter int CNTW   = 8,
    parameter int WINW   = 16
);
    localparam int LW = $clog2(MAXLEN + 1);

    logic              start;
    logic              abort;
    logic [MAXLEN-1:0] cfg_pattern;
    logic [LW-1:0]     cfg_len;
    logic [CNTW-1:0]   cfg_target;
    logic [WINW-1:0]   cfg_window;
    logic              din;
    logic              din_valid;
    logic              busy;
    logic              match;
    logic [CNTW-1:0]   match_count;
    logic              done;
    logic              timeout;
    logic              cfg_err;

    modport master (
        output start, abort, cfg_pattern, cfg_len, cfg_target, cfg_window, din, din_valid,
        input  busy, match, match_count, done, timeout, cfg_err
    );

    modport slave (
        input  start, abort, cfg_pattern, cfg_len, cfg_target, cfg_window, din, din_valid,
        output busy, match, match_count, done, timeout, cfg_err
    );
endinterface

// File: rtl/seq_match_ctrl.sv
// rtl/seq_match_ctrl.sv - programmable serial pattern search with overlap, target count and bit window
module seq_match_ctrl #(
    parameter int MAXLEN = 8,
    parameter int CNTW   = 8,
    parameter int WINW   = 16
) (
    input  logic            clk,
    input  logic            resetn,
    seq_match_ctrl_if.slave bus
);
    localparam int LW = $clog2(MAXLEN + 1);

    typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [MAXLEN-1:0] pat_q, pat_d;
    logic [LW-1:0]     len_q, len_d;
    logic [CNTW-1:0]   target_q, target_d;
    logic [WINW-1:0]   window_q, window_d;
    logic [MAXLEN-1:0] hist_q, hist_d;
    logic [WINW-1:0]   bits_q, bits_d;
    logic [CNTW-1:0]   count_q, count_d;
    logic              match_q, match_d;
    logic              timeout_q, timeout_d;
    logic              cfg_err_q, cfg_err_d;

    logic [MAXLEN-1:0] hist_new, len_mask;
    logic [WINW-1:0]   bits_new;
    logic [CNTW-1:0]   cnt_new;
    logic              len_ok, bit_ev, pat_hit, is_match, success, win_exh;

    // Abort suppresses the bit entirely, so a coincident completing bit is never counted.
    assign bit_ev   = (state_q == S_SEARCH) && bus.din_valid && !bus.abort;
    assign hist_new = {hist_q[MAXLEN-2:0], bus.din};
    assign len_mask = {MAXLEN{1'b1}} >> (LW'(MAXLEN) - len_q);
    assign pat_hit  = ((hist_new ^ pat_q) & len_mask) == '0;
    assign bits_new = (bits_q == '1) ? bits_q : bits_q + WINW'(1);
    assign cnt_new  = (count_q == '1) ? count_q : count_q + CNTW'(1);
    assign is_match = bit_ev && (bits_new >= WINW'(len_q)) && pat_hit;
    assign success  = is_match && (cnt_new == target_q);
    assign win_exh  = bit_ev && (window_q != '0) && (bits_new == window_q);
    assign len_ok   = (bus.cfg_len != '0) && (bus.cfg_len <= LW'(MAXLEN));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            pat_q     <= '0;
            len_q     <= '0;
            target_q  <= '0;
            window_q  <= '0;
            hist_q    <= '0;
            bits_q    <= '0;
            count_q   <= '0;
            match_q   <= 1'b0;
            timeout_q <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            target_q  <= target_d;
            window_q  <= window_d;
            hist_q    <= hist_d;
            bits_q    <= bits_d;
            count_q   <= count_d;
            match_q   <= match_d;
            timeout_q <= timeout_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (bus.start) state_d = len_ok ? S_SEARCH : S_DONE;
            S_SEARCH: begin
                if (bus.abort)               state_d = S_IDLE;
                else if (success || win_exh) state_d = S_DONE;
            end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pat_d     = pat_q;
        len_d     = len_q;
        target_d  = target_q;
        window_d  = window_q;
        hist_d    = hist_q;
        bits_d    = bits_q;
        count_d   = count_q;
        match_d   = 1'b0;
        timeout_d = timeout_q;
        cfg_err_d = cfg_err_q;
        if (state_q == S_IDLE && bus.start) begin
            count_d   = '0;
            timeout_d = 1'b0;
            cfg_err_d = !len_ok;
            if (len_ok) begin
                pat_d    = bus.cfg_pattern;
                len_d    = bus.cfg_len;
                target_d = (bus.cfg_target == '0) ? CNTW'(1) : bus.cfg_target;
                window_d = bus.cfg_window;
                hist_d   = '0;
                bits_d   = '0;
            end
        end else if (bit_ev) begin
            hist_d = hist_new;
            bits_d = bits_new;
            if (is_match) begin
                match_d = 1'b1;
                count_d = cnt_new;
            end
            if (win_exh && !success) timeout_d = 1'b1;
        end
    end

    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = (state_q == S_DONE);
    assign bus.match       = match_q;
    assign bus.match_count = count_q;
    assign bus.timeout     = timeout_q;
    assign bus.cfg_err     = cfg_err_q;
endmodule

// File: tb/tb_seq_match_ctrl.sv
// tb/tb_seq_match_ctrl.sv - directed self-checking bench for seq_match_ctrl
module tb_seq_match_ctrl;
    localparam int MAXLEN = 8;
    localparam int CNTW   = 8;
    localparam int WINW   = 16;
    localparam int LW     = $clog2(MAXLEN + 1);

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   tests_run = 0;
    int   tests_failed = 0;

    seq_match_ctrl_if #(.MAXLEN(MAXLEN), .CNTW(CNTW), .WINW(WINW)) bus ();

    seq_match_ctrl #(.MAXLEN(MAXLEN), .CNTW(CNTW), .WINW(WINW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.start = 0; bus.abort = 0; bus.din = 0; bus.din_valid = 0;
        bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_target = '0; bus.cfg_window = '0;
    endtask

    task automatic do_start(input logic [MAXLEN-1:0] pat, input int len, input int tgt, input int win);
        bus.cfg_pattern = pat;
        bus.cfg_len     = LW'(len);
        bus.cfg_target  = CNTW'(tgt);
        bus.cfg_window  = WINW'(win);
        bus.start       = 1;
        tick();
        bus.start       = 0;
    endtask

    task automatic drive_bit(input int b, input int v);
        bus.din       = b[0];
        bus.din_valid = v[0];
        tick();
        bus.din_valid = 0;
    endtask

    task automatic test_reset;
        idle_inputs();
        resetn = 0;
        tick(); tick();
        resetn = 1;
        tick();
        tests_run++;
        if ({bus.busy, bus.match, bus.done, bus.timeout, bus.cfg_err, bus.match_count} !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: got busy=%b match=%b done=%b timeout=%b cfg_err=%b count=%0d, want all 0",
                     bus.busy, bus.match, bus.done, bus.timeout, bus.cfg_err, bus.match_count);
        end
    endtask

    task automatic test_basic;
        int b[6]  = '{1, 0, 1, 0, 1, 0};
        int em[6] = '{0, 0, 0, 1, 0, 1};
        int ec[6] = '{0, 0, 0, 1, 1, 2};
        int ed[6] = '{0, 0, 0, 0, 0, 1};
        do_start(8'b0000_1010, 4, 2, 0);
        tests_run++;
        if (bus.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_busy_after_start: got %b want 1", bus.busy);
        end
        for (int i = 0; i < 6; i++) begin
            drive_bit(b[i], 1);
            tests_run++;
            if ({bus.match, bus.done, bus.match_count} !== {1'(em[i]), 1'(ed[i]), CNTW'(ec[i])}) begin
                tests_failed++;
                $display("FAIL basic_bit%0d: got match=%b done=%b count=%0d, want %0d %0d %0d",
                         i + 1, bus.match, bus.done, bus.match_count, em[i], ed[i], ec[i]);
            end
        end
        tests_run++;
        if (bus.timeout !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_timeout: got %b want 0", bus.timeout);
        end
        tick();
        tests_run++;
        if ({bus.busy, bus.done, bus.match, bus.match_count} !== {3'b000, CNTW'(2)}) begin
            tests_failed++;
            $display("FAIL basic_after_done: got busy=%b done=%b match=%b count=%0d, want 0 0 0 2",
                     bus.busy, bus.done, bus.match, bus.match_count);
        end
    endtask

    task automatic test_overlap;
        int em[5] = '{0, 0, 1, 1, 1};
        int ec[5] = '{0, 0, 1, 2, 3};
        int ed[5] = '{0, 0, 0, 0, 1};
        do_start(8'b0000_0111, 3, 3, 0);
        for (int i = 0; i < 5; i++) begin
            if (i == 0) begin
                bus.start   = 1;
                bus.cfg_len = '0;
            end
            drive_bit(1, 1);
            bus.start = 0;
            tests_run++;
            if ({bus.match, bus.done, bus.match_count, bus.cfg_err} !== {1'(em[i]), 1'(ed[i]), CNTW'(ec[i]), 1'b0}) begin
                tests_failed++;
                $display("FAIL overlap_bit%0d: got match=%b done=%b count=%0d cfg_err=%b, want %0d %0d %0d 0",
                         i + 1, bus.match, bus.done, bus.match_count, bus.cfg_err, em[i], ed[i], ec[i]);
            end
        end
        tick();
    endtask

    task automatic test_window;
        int b[6]  = '{0, 1, 1, 1, 1, 1};
        int em[6] = '{0, 1, 0, 0, 0, 0};
        int ed[6] = '{0, 0, 0, 0, 0, 1};
        int ec[6] = '{0, 1, 1, 1, 1, 1};
        do_start(8'b0000_0001, 2, 5, 6);
        for (int i = 0; i < 6; i++) begin
            drive_bit(b[i], 1);
            tests_run++;
            if ({bus.match, bus.done, bus.match_count} !== {1'(em[i]), 1'(ed[i]), CNTW'(ec[i])}) begin
                tests_failed++;
                $display("FAIL window_bit%0d: got match=%b done=%b count=%0d, want %0d %0d %0d",
                         i + 1, bus.match, bus.done, bus.match_count, em[i], ed[i], ec[i]);
            end
        end
        tests_run++;
        if (bus.timeout !== 1'b1) begin
            tests_failed++;
            $display("FAIL window_timeout: got %b want 1", bus.timeout);
        end
        tick();
        tests_run++;
        if ({bus.busy, bus.timeout} !== 2'b01) begin
            tests_failed++;
            $display("FAIL window_hold: got busy=%b timeout=%b, want 0 1", bus.busy, bus.timeout);
        end
    endtask

    task automatic test_success_beats_window;
        int b[4] = '{1, 0, 1, 0};
        do_start(8'b0000_1010, 4, 0, 4);
        for (int i = 0; i < 4; i++) drive_bit(b[i], 1);
        tests_run++;
        if ({bus.match, bus.done, bus.timeout, bus.match_count} !== {3'b110, CNTW'(1)}) begin
            tests_failed++;
            $display("FAIL success_vs_window: got match=%b done=%b timeout=%b count=%0d, want 1 1 0 1",
                     bus.match, bus.done, bus.timeout, bus.match_count);
        end
        tick();
    endtask

    task automatic test_gated;
        int b[6]  = '{1, 0, 1, 0, 1, 0};
        int ec[6] = '{0, 0, 0, 1, 1, 2};
        int cnt = 0;
        do_start(8'b0000_1010, 4, 2, 0);
        for (int i = 0; i < 12; i++) begin
            int j = i / 2;
            int em, ed;
            if (i % 2 == 0) begin
                drive_bit(~b[j] & 1, 0);
                em = 0; ed = 0;
            end else begin
                drive_bit(b[j], 1);
                em = (ec[j] != cnt) ? 1 : 0;
                cnt = ec[j];
                ed = (j == 5) ? 1 : 0;
            end
            tests_run++;
            if ({bus.match, bus.done, bus.match_count} !== {1'(em), 1'(ed), CNTW'(cnt)}) begin
                tests_failed++;
                $display("FAIL gated_cycle%0d: got match=%b done=%b count=%0d, want %0d %0d %0d",
                         i, bus.match, bus.done, bus.match_count, em, ed, cnt);
            end
        end
        tick();
    endtask

    task automatic test_cfg_err;
        int bad[2] = '{0, 9};
        for (int k = 0; k < 2; k++) begin
            do_start(8'b0000_0011, bad[k], 1, 0);
            tests_run++;
            if ({bus.done, bus.cfg_err, bus.busy, bus.match_count} !== {3'b111, CNTW'(0)}) begin
                tests_failed++;
                $display("FAIL cfg_err_len%0d: got done=%b cfg_err=%b busy=%b count=%0d, want 1 1 1 0",
                         bad[k], bus.done, bus.cfg_err, bus.busy, bus.match_count);
            end
            // start held through the DONE cycle is ignored, then accepted in the first IDLE cycle
            bus.cfg_len = LW'(2);
            bus.start   = 1;
            tick();
            tests_run++;
            if ({bus.busy, bus.done, bus.cfg_err} !== 3'b001) begin
                tests_failed++;
                $display("FAIL cfg_err_hold_len%0d: got busy=%b done=%b cfg_err=%b, want 0 0 1",
                         bad[k], bus.busy, bus.done, bus.cfg_err);
            end
            tick();
            bus.start = 0;
            tests_run++;
            if ({bus.busy, bus.cfg_err} !== 2'b10) begin
                tests_failed++;
                $display("FAIL cfg_err_b2b_len%0d: got busy=%b cfg_err=%b, want 1 0", bad[k], bus.busy, bus.cfg_err);
            end
            bus.abort = 1;
            tick();
            bus.abort = 0;
        end
    endtask

    task automatic test_abort;
        int b[5] = '{1, 0, 1, 0, 1};
        do_start(8'b0000_1010, 4, 4, 0);
        for (int i = 0; i < 5; i++) drive_bit(b[i], 1);
        bus.abort = 1;
        drive_bit(0, 1);
        bus.abort = 0;
        tests_run++;
        if ({bus.busy, bus.done, bus.match, bus.timeout, bus.cfg_err, bus.match_count} !== {5'b00000, CNTW'(1)}) begin
            tests_failed++;
            $display("FAIL abort_plain: got busy=%b done=%b match=%b timeout=%b cfg_err=%b count=%0d, want 0 0 0 0 0 1",
                     bus.busy, bus.done, bus.match, bus.timeout, bus.cfg_err, bus.match_count);
        end
        do_start(8'b0000_1010, 4, 3, 0);
        for (int i = 0; i < 5; i++) drive_bit(b[i], 1);
        drive_bit(0, 1);
        drive_bit(1, 1);
        bus.abort = 1;
        drive_bit(0, 1);
        bus.abort = 0;
        tests_run++;
        if ({bus.busy, bus.done, bus.match, bus.match_count} !== {3'b000, CNTW'(2)}) begin
            tests_failed++;
            $display("FAIL abort_wins: got busy=%b done=%b match=%b count=%0d, want 0 0 0 2",
                     bus.busy, bus.done, bus.match, bus.match_count);
        end
        tick();
        tests_run++;
        if ({bus.busy, bus.done, bus.match_count} !== {2'b00, CNTW'(2)}) begin
            tests_failed++;
            $display("FAIL abort_hold: got busy=%b done=%b count=%0d, want 0 0 2", bus.busy, bus.done, bus.match_count);
        end
    endtask

    task automatic test_reset_mid_search;
        int b[4] = '{1, 0, 1, 0};
        do_start(8'b0000_1010, 4, 4, 0);
        for (int i = 0; i < 4; i++) drive_bit(b[i], 1);
        #2;
        resetn = 0;
        #1;
        tests_run++;
        if ({bus.busy, bus.match, bus.done, bus.timeout, bus.cfg_err, bus.match_count} !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid_search: got busy=%b match=%b done=%b timeout=%b cfg_err=%b count=%0d, want all 0",
                     bus.busy, bus.match, bus.done, bus.timeout, bus.cfg_err, bus.match_count);
        end
        #1;
        resetn = 1;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overlap();
        test_window();
        test_success_beats_window();
        test_gated();
        test_cfg_err();
        test_abort();
        test_reset_mid_search();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/seq_match_ctrl.md
# seq_match_ctrl

Programmable serial pattern-search controller. On a start command it captures a pattern (1 to MAXLEN bits), a target match count and an optional bit window, then scans a gated serial bitstream with overlapping matches. It finishes on target reached, window exhausted, abort, or bad configuration. It sits between a command source (CSR/sequencer) and a serial data lane, replacing fixed hard-coded detector FSMs with one configurable, sequenced resource.

## Interface
- MAXLEN, 8: maximum pattern length in bits (2..16)
- CNTW, 8: width of match counter and target
- WINW, 16: width of window and bit counters
- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- start  in  1  command pulse; honoured only in IDLE
- abort  in  1  cancel search; honoured only in SEARCH
- cfg_pattern  in  MAXLEN  pattern; bit cfg_len-1 is the first bit expected on the wire
- cfg_len  in  $clog2(MAXLEN+1)  pattern length, legal 1..MAXLEN
- cfg_target  in  CNTW  matches required; 0 is treated as 1
- cfg_window  in  WINW  max bits examined; 0 = unlimited
- din  in  1  serial data bit
- din_valid  in  1  din qualifier; bits with din_valid=0 are ignored
- busy  out  1  high in SEARCH and DONE
- match  out  1  one-cycle pulse per pattern occurrence
- match_count  out  CNTW  matches in current/last search
- done  out  1  one-cycle completion pulse
- timeout  out  1  last search ended by window exhaustion
- cfg_err  out  1  last start had illegal cfg_len

## Operation
- States: IDLE, SEARCH, DONE. Reset -> IDLE.
- IDLE + start, legal cfg_len: latch pattern/len/target/window; clear history, bit counter, match_count, timeout, cfg_err; -> SEARCH.
- IDLE + start, cfg_len==0 or >MAXLEN: set cfg_err=1, clear match_count and timeout; -> DONE.
- SEARCH, per bit with din_valid=1: history <= {history[MAXLEN-2:0], din}; bits_seen++.
- Match when bits_seen (including the current bit) >= len and the low len bits of updated history equal the low len bits of the latched pattern. Overlap is allowed: history is never flushed on a match.
- On match: match pulses and match_count increments, saturating at all-ones.
- Success: match_count reaches the effective target -> DONE, timeout=0.
- Window: window!=0 and bits_seen reaches window without success -> DONE, timeout=1.
- Same bit both completes the target and exhausts the window: success wins, timeout=0.
- Abort in SEARCH: -> IDLE. No done. match_count is held; timeout/cfg_err stay 0.
- Abort and a completing bit in the same cycle: abort wins; the match is not counted.
- start outside IDLE and abort outside SEARCH are ignored.
- DONE: lasts exactly one cycle, then -> IDLE.
- match_count, timeout and cfg_err hold until the next accepted start.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values.
- Reset values: busy=0, match=0, match_count=0, done=0, timeout=0, cfg_err=0.

## Timing
- start sampled at edge E: SEARCH and busy=1 from E. din at edge E is not examined; the first examined bit is sampled at E+1.
- Outputs are registered. A bit sampled at edge K that completes a match gives match=1 and the incremented match_count in cycle K..K+1.
- Completing bit at edge K: DONE (done=1) in cycle K..K+1, coincident with the final match pulse. IDLE and busy=0 from K+1.
- Back-to-back operation: a start in the first IDLE cycle after DONE is accepted.
- cfg_err path: start at E gives done=1 and cfg_err=1 in cycle E..E+1.
- din_valid=0 cycles add latency only; they never reset history.

## Test plan
- Pattern 4'b1010, len=4, target=2, window=0; stream 1,0,1,0,1,0 valid every cycle -> match after bits 4 and 6; done with count=2 on bit 6; timeout=0.
- Pattern 3'b111, len=3, target=3; stream 1,1,1,1,1 -> matches on bits 3, 4 and 5 (overlap); done on bit 5, count=3.
- Pattern 2'b01, target=5, window=6; stream 0,1,1,1,1,1 -> one match; done on bit 6 with timeout=1, count=1.
- Same as the first case, but din_valid low on alternate cycles with garbage on din -> identical match/count sequence, spread over 2x cycles.
- cfg_len=0 start -> done and cfg_err next cycle, count=0. Then a legal start -> cfg_err clears.
- Abort after 2 matches (target 4) -> IDLE, no done, count stays 2. Reset asserted mid-SEARCH -> all outputs 0 asynchronously.
